sipo_receiver: RTL
==================

# sipo_receiver

Serial-in, parallel-out receiver for the 8-bit MSB-first serial stream produced by the team's parallel-load shift transmitter. It samples one bit per qualified clock edge, assembles each complete word, and presents it on a parallel port. The word is held under a valid/ack handshake with overrun detection. It sits at the receive end of the serial link, between the pin-side serial line and the consuming parallel logic.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- sin  input  1  serial data bit, MSB of each word first
- shift_en  input  1  sample `sin` on this edge
- frame_sync  input  1  discard any partial word and restart framing
- pout  output  WIDTH  last completed word; first received bit in `pout[WIDTH-1]`
- pout_valid  output  1  level; `pout` holds an unconsumed word
- pout_ack  input  1  consumer takes `pout`; clears `pout_valid`
- busy  output  1  partial word in progress (bit count ≠ 0)
- overrun  output  1  sticky; a completed word was dropped
- parity_err  output  1  parity flag for the word in `pout`; see Configuration

## Operation
- Register FSM with three states.
  - IDLE: bit count 0.
  - DATA: collecting data bits.
  - PAR: expecting the parity bit; present only with the macro.
- Each edge with `shift_en=1` samples `sin`: `shreg <= {shreg[WIDTH-2:0], sin}`. The bit count increments modulo the frame length.
- Frame length is WIDTH bits, or WIDTH+1 bits with parity.
- On the edge that samples the final bit of a frame:
  - `pout` loads the assembled word.
  - `pout_valid` is set to 1.
  - The count wraps to 0 and the FSM returns to IDLE.
- `pout_ack` while `pout_valid=1` clears `pout_valid`. `pout_ack` while `pout_valid=0` is ignored.
- A word that completes while `pout_valid=1` and `pout_ack=0`:
  - The new word is dropped.
  - `pout` keeps the old word.
  - `overrun` is set.
- A word that completes on the same edge as `pout_ack`: the new word is loaded, `pout_valid` stays 1, and there is no overrun.
- `overrun` clears only on `rst`.
- `frame_sync=1` resets the bit count to 0 and discards the partial word. If `shift_en=1` on the same edge, that `sin` is taken as bit 1 (the MSB) of the new frame, and the count becomes 1.
- `frame_sync` does not affect `pout`, `pout_valid` or `overrun`.
- With `shift_en=0`, all state holds, apart from the ack and sync effects above.

## Timing
- Reset values:
  - `pout`=0, `pout_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0.
  - Shift register and bit count are 0; FSM is in IDLE.
- Asserting `rst` mid-word discards the partial word immediately and asynchronously.
- All outputs are registered; no combinational path from input to output.
- `pout_valid` is high in the cycle after the edge that sampled the last bit, so latency is 0 cycles after the final sample edge.
- Back-to-back words with `shift_en` held high: one completed word every WIDTH cycles, or every WIDTH+1 cycles with parity.
- A consumer that acks in the cycle `pout_valid` rises never causes overrun.

## Configuration
- Macro: `SIPO_RECEIVER_PARITY_EN`.
- Defined:
  - Each frame carries WIDTH data bits plus one trailing even-parity bit, and the PAR state exists.
  - `parity_err` loads `^{data, parity_bit}` together with `pout`. It is valid while `pout_valid=1`.
  - A dropped (overrun) word does not update `parity_err`.
- Undefined:
  - Frames are WIDTH bits and the PAR state is absent.
  - The `parity_err` port remains in the interface and is tied to 0.

## Structure
- Shared package `sipo_pkg`:
  - FSM state typedef (IDLE, DATA, PAR).
  - Default WIDTH constant (8).
  - Bit-count width function `$clog2(WIDTH+2)`.
- One sub-module, `sipo_shift_core`: the shift register plus bit counter with sync handling. The top level holds the FSM, the handshake, overrun and parity logic.

## Test plan
- Reset, then shift `sin` = 1,0,1,0,0,1,0,1 with `shift_en=1` and no ack -> `pout`=8'hA5 and `pout_valid`=1 after the 8th edge; `busy` is 0 afterwards.
- Shift 3 bits, pulse `frame_sync` with `shift_en`=1 and `sin`=0, then 7 more bits 1,1,1,1,1,1,1 -> `pout`=8'h7F; the partial bits are discarded.
- Complete 8'h3C without ack, then complete 8'hFF -> `pout` stays 8'h3C, `overrun`=1, `pout_valid`=1.
- Complete 8'h12 and 8'h34 back-to-back, with `pout_ack` asserted on the 8'h34 completion edge -> `pout`=8'h34, `pout_valid`=1, `overrun`=0.
- Assert `rst` asynchronously after 5 bits -> all outputs go to 0 before the next edge; a following full word 8'h81 is received correctly.
- With the macro defined: send 8'hA5 then parity bit 0 -> `parity_err`=0. Send 8'hA5 then parity bit 1 -> `parity_err`=1; `pout` is 8'hA5 in both cases.

Source files
------------

// File: rtl/sipo_pkg.sv
// ============================================================================
// Module  : sipo_pkg
// Purpose : Shared FSM state type, default width and counter sizing for the
//           serial-in parallel-out receiver.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } sipo_state_e;

  localparam int C_DEFAULT_WIDTH = 8;

  // Counter must hold values up to WIDTH (parity slot) with headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift_core.sv
// ============================================================================
// Module  : sipo_shift_core
// Purpose : Shift register and bit counter with frame-sync restart; flags the
//           edge that samples the last bit of a frame.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = C_DEFAULT_WIDTH,
  parameter int FRAME_LEN = C_DEFAULT_WIDTH,
  parameter bit PARITY_EN = 1'b0,
  parameter int CW        = cnt_width(C_DEFAULT_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             shift_en,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] word,
  output logic             frame_done,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_base;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;

  always_comb begin
    // A sync discards the partial word before this edge's sample is applied.
    cnt_base   = frame_sync ? '0 : cnt_q;
    shreg_base = frame_sync ? '0 : shreg_q;
    cnt_d      = cnt_base;
    shreg_d    = shreg_base;
    frame_done = 1'b0;
    if (shift_en) begin
      shreg_d = {shreg_base[WIDTH-2:0], sin};
      if (cnt_base == CW'(FRAME_LEN - 1)) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_base + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // With parity the final sample is the parity bit, so the data is already held.
  generate
    if (PARITY_EN) begin : g_par_word
      assign word = shreg_q;
    end else begin : g_data_word
      assign word = shreg_d;
    end
  endgenerate

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/sipo_receiver.sv
// ============================================================================
// Module  : sipo_receiver
// Purpose : MSB-first serial receiver with valid/ack output handshake and
//           sticky overrun. Define SIPO_RECEIVER_PARITY_EN for even parity.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             shift_en,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ack,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_RECEIVER_PARITY_EN
  localparam bit C_PARITY_EN = 1'b1;
`else
  localparam bit C_PARITY_EN = 1'b0;
`endif
  localparam int C_FRAME_LEN = WIDTH + (C_PARITY_EN ? 1 : 0);
  localparam int C_CW        = cnt_width(WIDTH);

  logic [WIDTH-1:0] word;
  logic             frame_done;
  logic [C_CW-1:0]  cnt;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (C_FRAME_LEN),
    .PARITY_EN (C_PARITY_EN),
    .CW        (C_CW)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .shift_en   (shift_en),
    .frame_sync (frame_sync),
    .word       (word),
    .frame_done (frame_done),
    .cnt        (cnt)
  );

  sipo_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (frame_sync) begin
      state_d = shift_en ? ST_DATA : ST_IDLE;
    end else if (shift_en) begin
      case (state_q)
        ST_IDLE: state_d = ST_DATA;
        ST_DATA: if (cnt == C_CW'(WIDTH - 1)) state_d = C_PARITY_EN ? ST_PAR : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             take_word;

  always_comb begin
    pout_d    = pout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    take_word = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    if (pout_ack) valid_d = 1'b0;
    // An ack on the completion edge frees the slot for the new word.
    if (frame_done) begin
      if (valid_q && !pout_ack) begin
        overrun_d = 1'b1;
      end else begin
        pout_d    = word;
        valid_d   = 1'b1;
        take_word = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pout_q    <= pout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

`ifdef SIPO_RECEIVER_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (take_word) perr_d = ^{word, sin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`else
  logic unused_take;
  assign unused_take = take_word;
  assign parity_err  = 1'b0;
`endif

  assign pout       = pout_q;
  assign pout_valid = valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire
